// File: rtl/spike_phase_if.sv
// Output bundle of spike_phase_encoder: per-cycle first-spike phases, fired flags,
// saturating spike counts and the learning-rule strobe.
interface spike_phase_if #(
    parameter int PHASE_W = 8,
    parameter int CNT_W   = 4
);
    logic [PHASE_W-1:0] phase_pre;
    logic [PHASE_W-1:0] phase_post;
    logic               fired_pre;
    logic               fired_post;
    logic [CNT_W-1:0]   cnt_pre;
    logic [CNT_W-1:0]   cnt_post;
    logic               stdp_start;

    modport master (
        output phase_pre, phase_post, fired_pre, fired_post,
        output cnt_pre, cnt_post, stdp_start
    );

    modport slave (
        input phase_pre, phase_post, fired_pre, fired_post,
        input cnt_pre, cnt_post, stdp_start
    );
endinterface

// File: rtl/spike_phase_encoder.sv
// Time-stamps the first pre/post spike of each gamma cycle with the oscillator phase
// and presents the completed cycle, double-buffered, to the phase-STDP rule.
module spike_phase_encoder #(
    parameter int PHASE_W     = 8,
    parameter int CNT_W       = 4,
    parameter int EDGE_DETECT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PHASE_W-1:0] gphase,
    input  logic               cycle_start,
    input  logic               spike_pre,
    input  logic               spike_post,
    spike_phase_if.master      enc
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : (v + CNT_ONE);
    endfunction

    // Channel index 0 is pre, 1 is post.
    logic [1:0]         spike_s;
    logic [1:0]         spike_d_r;
    logic [1:0]         event_s;
    logic [1:0]         cap_fired_r;
    logic [1:0]         cap_fired_nxt_s;
    logic [PHASE_W-1:0] cap_phase_r     [2];
    logic [PHASE_W-1:0] cap_phase_nxt_s [2];
    logic [CNT_W-1:0]   cap_cnt_r       [2];
    logic [CNT_W-1:0]   cap_cnt_base_s  [2];
    logic [CNT_W-1:0]   cap_cnt_nxt_s   [2];

    logic [PHASE_W-1:0] phase_pre_r;
    logic [PHASE_W-1:0] phase_post_r;
    logic               fired_pre_r;
    logic               fired_post_r;
    logic [CNT_W-1:0]   cnt_pre_r;
    logic [CNT_W-1:0]   cnt_post_r;
    logic               stdp_start_r;

    assign spike_s = {spike_post, spike_pre};

    // Spike event: rising edge or raw level depending on EDGE_DETECT.
    always_comb begin
        if (EDGE_DETECT != 0) begin
            event_s = spike_s & ~spike_d_r;
        end else begin
            event_s = spike_s;
        end
    end

    // Next capture state; on a boundary clk the set restarts, and a coincident
    // event belongs to the new cycle.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            cap_fired_nxt_s[i] = (cap_fired_r[i] & ~cycle_start) | event_s[i];
            if (event_s[i] && (cycle_start || !cap_fired_r[i])) begin
                cap_phase_nxt_s[i] = gphase;
            end else if (cycle_start) begin
                cap_phase_nxt_s[i] = '0;
            end else begin
                cap_phase_nxt_s[i] = cap_phase_r[i];
            end
            cap_cnt_base_s[i] = cycle_start ? '0 : cap_cnt_r[i];
            if (event_s[i]) begin
                cap_cnt_nxt_s[i] = sat_inc(cap_cnt_base_s[i]);
            end else begin
                cap_cnt_nxt_s[i] = cap_cnt_base_s[i];
            end
        end
    end

    // Capture registers, edge history, output set and strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike_d_r    <= 2'b00;
            cap_fired_r  <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                cap_phase_r[i] <= '0;
                cap_cnt_r[i]   <= '0;
            end
            phase_pre_r  <= '0;
            phase_post_r <= '0;
            fired_pre_r  <= 1'b0;
            fired_post_r <= 1'b0;
            cnt_pre_r    <= '0;
            cnt_post_r   <= '0;
            stdp_start_r <= 1'b0;
        end else begin
            spike_d_r    <= spike_s;
            cap_fired_r  <= cap_fired_nxt_s;
            for (int i = 0; i < 2; i++) begin
                cap_phase_r[i] <= cap_phase_nxt_s[i];
                cap_cnt_r[i]   <= cap_cnt_nxt_s[i];
            end
            stdp_start_r <= cycle_start;
            if (cycle_start) begin
                phase_pre_r  <= cap_fired_r[0] ? cap_phase_r[0] : '0;
                phase_post_r <= cap_fired_r[1] ? cap_phase_r[1] : '0;
                fired_pre_r  <= cap_fired_r[0];
                fired_post_r <= cap_fired_r[1];
                cnt_pre_r    <= cap_cnt_r[0];
                cnt_post_r   <= cap_cnt_r[1];
            end
        end
    end

    assign enc.phase_pre  = phase_pre_r;
    assign enc.phase_post = phase_post_r;
    assign enc.fired_pre  = fired_pre_r;
    assign enc.fired_post = fired_post_r;
    assign enc.cnt_pre    = cnt_pre_r;
    assign enc.cnt_post   = cnt_post_r;
    assign enc.stdp_start = stdp_start_r;

endmodule
